// File: rtl/mips_main_control_32.sv
// Multi-cycle main control FSM for the 32-bit MIPS datapath: sequences fetch, decode,
// ALU execution (start/finish handshake), memory access and write-back, with a sticky error halt.
module mips_main_control_32 #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  input  logic        alu_finish,
  input  logic        alu_zero,
  input  logic        err_illegal_func_code,
  input  logic        err_illegal_alu_op,
  output logic [1:0]  alu_op,
  output logic        alu_start,
  output logic        mem_read,
  output logic        mem_write,
  output logic        i_or_d,
  output logic        ir_write,
  output logic        pc_write,
  output logic        branch_taken,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        halted,
  output logic [2:0]  err_code,
  output logic [31:0] instr_count,
  output logic [2:0]  state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  localparam logic [1:0] C_R   = 2'd0;
  localparam logic [1:0] C_LW  = 2'd1;
  localparam logic [1:0] C_SW  = 2'd2;
  localparam logic [1:0] C_BEQ = 2'd3;

  localparam logic [2:0] E_NONE    = 3'b000;
  localparam logic [2:0] E_OPCODE  = 3'b001;
  localparam logic [2:0] E_FUNC    = 3'b010;
  localparam logic [2:0] E_ALU_OP  = 3'b011;
  localparam logic [2:0] E_TIMEOUT = 3'b100;

  // Counter only needs to reach TIMEOUT; one spare bit keeps the increment from wrapping.
  localparam int               CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // {legal, class} for the opcode field.
  function automatic logic [2:0] decode_opcode(input logic [5:0] op);
    case (op)
      6'b000000: return {1'b1, C_R};
      6'b100011: return {1'b1, C_LW};
      6'b101011: return {1'b1, C_SW};
      6'b000100: return {1'b1, C_BEQ};
      default:   return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] class_alu_op(input logic [1:0] cls);
    case (cls)
      C_R:     return 2'b10;
      C_BEQ:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  logic [2:0]       state_q, state_d;
  logic [2:0]       err_q, err_d;
  logic [1:0]       cls_q;
  logic [CNT_W-1:0] wait_cnt_q;
  logic [31:0]      instr_cnt_q;
  logic [2:0]       opc_dec;
  logic             exec_first;
  logic             finish_ok;
  logic             retire;

  assign opc_dec    = decode_opcode(opcode);
  assign exec_first = (wait_cnt_q == '0);
  assign finish_ok  = !exec_first && alu_finish && !err_illegal_func_code && !err_illegal_alu_op;
  assign retire     = (state_d == S_FETCH) &&
                      ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (opc_dec[2]) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_ERROR;
          err_d   = E_OPCODE;
        end
      end
      S_EXEC: begin
        // A finish seen on the timeout cycle still completes the instruction.
        if (!exec_first && alu_finish) begin
          if (err_illegal_func_code) begin
            state_d = S_ERROR;
            err_d   = E_FUNC;
          end else if (err_illegal_alu_op) begin
            state_d = S_ERROR;
            err_d   = E_ALU_OP;
          end else begin
            case (cls_q)
              C_R:   state_d = S_WB;
              C_LW:  state_d = S_MEM;
              C_SW:  state_d = S_MEM;
              C_BEQ: state_d = S_FETCH;
            endcase
          end
        end else if (wait_cnt_q == CNT_LAST) begin
          state_d = S_ERROR;
          err_d   = E_TIMEOUT;
        end
      end
      S_MEM:    if (mem_ready) state_d = (cls_q == C_LW) ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      S_ERROR:  state_d = S_ERROR;
      default: begin
        state_d = S_ERROR;
        err_d   = E_TIMEOUT;
      end
    endcase
  end

  always_comb begin
    alu_op       = 2'b00;
    alu_start    = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    i_or_d       = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    branch_taken = 1'b0;
    reg_write    = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    halted       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_EXEC: begin
        alu_op       = class_alu_op(cls_q);
        alu_start    = exec_first;
        branch_taken = (cls_q == C_BEQ) && finish_ok && alu_zero;
      end
      S_MEM: begin
        i_or_d    = 1'b1;
        mem_read  = (cls_q == C_LW);
        mem_write = (cls_q == C_SW);
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (cls_q == C_R);
        mem_to_reg = (cls_q == C_LW);
      end
      S_ERROR: halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q       <= E_NONE;
      cls_q       <= C_R;
      wait_cnt_q  <= '0;
      instr_cnt_q <= '0;
    end else begin
      err_q <= err_d;
      if (state_q == S_DECODE && opc_dec[2]) cls_q <= opc_dec[1:0];
      // Cleared while decoding so the first EXEC cycle always sees zero.
      if (state_q == S_DECODE)    wait_cnt_q <= '0;
      else if (state_q == S_EXEC) wait_cnt_q <= wait_cnt_q + CNT_ONE;
      if (retire) instr_cnt_q <= instr_cnt_q + 32'd1;
    end
  end

  assign err_code    = err_q;
  assign instr_count = instr_cnt_q;
  assign state       = state_q;

endmodule

// File: tb/tb_mips_main_control_32.sv
// Scoreboard bench for mips_main_control_32: per-cycle expectations are queued as
// stimulus is driven and compared against state, control outputs and instr_count.
module tb_mips_main_control_32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        mem_ready, alu_finish, alu_zero;
  logic        err_illegal_func_code, err_illegal_alu_op;
  logic [1:0]  alu_op;
  logic        alu_start, mem_read, mem_write, i_or_d, ir_write, pc_write;
  logic        branch_taken, reg_write, reg_dst, mem_to_reg, halted;
  logic [2:0]  err_code;
  logic [31:0] instr_count;
  logic [2:0]  state;

  mips_main_control_32 #(.TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .alu_finish(alu_finish), .alu_zero(alu_zero),
    .err_illegal_func_code(err_illegal_func_code), .err_illegal_alu_op(err_illegal_alu_op),
    .alu_op(alu_op), .alu_start(alu_start), .mem_read(mem_read), .mem_write(mem_write),
    .i_or_d(i_or_d), .ir_write(ir_write), .pc_write(pc_write), .branch_taken(branch_taken),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .halted(halted),
    .err_code(err_code), .instr_count(instr_count), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic L = 1'b0;
  localparam logic H = 1'b1;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_BAD = 6'b000010;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DEC = 3'd2, ST_EXEC = 3'd3;
  localparam logic [2:0] ST_MEM = 3'd4, ST_WB = 3'd5, ST_ERR = 3'd6;

  localparam logic [15:0] O_NONE = 16'h0000;
  localparam logic [15:0] A_LS = 16'h0000, A_BEQ = 16'h4000, A_R = 16'h8000;
  localparam logic [15:0] O_START = 16'h2000, O_MRD = 16'h1000, O_MWR = 16'h0800;
  localparam logic [15:0] O_IOD = 16'h0400, O_IRW = 16'h0200, O_PCW = 16'h0100;
  localparam logic [15:0] O_BT = 16'h0080, O_RW = 16'h0040, O_RDST = 16'h0020;
  localparam logic [15:0] O_M2R = 16'h0010, O_HALT = 16'h0008;
  localparam logic [15:0] E_OPC = 16'h0001, E_FUNC = 16'h0002, E_ALUOP = 16'h0003, E_TMO = 16'h0004;
  localparam logic [15:0] O_FRDY = O_MRD | O_IRW | O_PCW;

  logic [15:0] obs_outs;
  assign obs_outs = {alu_op, alu_start, mem_read, mem_write, i_or_d, ir_write, pc_write,
                     branch_taken, reg_write, reg_dst, mem_to_reg, halted, err_code};

  typedef struct {
    string       tag;
    logic [2:0]  st;
    logic [15:0] outs;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_cnt = 32'd0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_head();
    exp_t g;
    g = sb_q.pop_front();
    check_eq({g.tag, ".state"}, 64'(state), 64'(g.st));
    check_eq({g.tag, ".outs"}, 64'(obs_outs), 64'(g.outs));
    check_eq({g.tag, ".count"}, 64'(instr_count), 64'(g.cnt));
  endtask

  // One clock cycle: drive inputs after the edge, queue what this cycle should show, sample mid-cycle.
  task automatic cyc(input string tag, input logic [5:0] op, input logic mr, input logic af,
                     input logic az, input logic efc, input logic eao,
                     input logic [2:0] st, input logic [15:0] outs);
    exp_t e;
    @(posedge clk);
    #1;
    opcode = op; mem_ready = mr; alu_finish = af; alu_zero = az;
    err_illegal_func_code = efc; err_illegal_alu_op = eao;
    e.tag = tag; e.st = st; e.outs = outs; e.cnt = exp_cnt;
    sb_q.push_back(e);
    #3;
    compare_head();
  endtask

  // Asynchronous reset mid-cycle: everything must clear before any clock edge.
  task automatic do_reset(input string tag);
    exp_t e;
    #1;
    rst_n = 1'b0;
    exp_cnt = 32'd0;
    e.tag = tag; e.st = ST_IDLE; e.outs = O_NONE; e.cnt = 32'd0;
    sb_q.push_back(e);
    #1;
    compare_head();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, summary not printed");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1;
    opcode = OP_R; mem_ready = L; alu_finish = L; alu_zero = L;
    err_illegal_func_code = L; err_illegal_alu_op = L;
    #2;
    do_reset("rst0");

    // R-type add; mem_ready is ignored in DECODE/EXEC
    cyc("r.f",  OP_R, H, L, L, L, L, ST_FETCH, O_FRDY);
    cyc("r.d",  OP_R, H, L, L, L, L, ST_DEC,   O_NONE);
    cyc("r.e0", OP_R, H, L, L, L, L, ST_EXEC,  A_R | O_START);
    cyc("r.e1", OP_R, L, H, L, L, L, ST_EXEC,  A_R);
    cyc("r.wb", OP_R, L, L, L, L, L, ST_WB,    O_RW | O_RDST);
    exp_cnt++;

    // lw with stalled fetch and slow memory
    cyc("lw.f0", OP_LW, L, L, L, L, L, ST_FETCH, O_MRD);
    cyc("lw.f1", OP_LW, L, L, L, L, L, ST_FETCH, O_MRD);
    cyc("lw.f2", OP_LW, H, L, L, L, L, ST_FETCH, O_FRDY);
    cyc("lw.d",  OP_LW, L, L, L, L, L, ST_DEC,   O_NONE);
    cyc("lw.e0", OP_LW, L, L, L, L, L, ST_EXEC,  A_LS | O_START);
    cyc("lw.e1", OP_LW, L, H, L, L, L, ST_EXEC,  A_LS);
    for (int i = 0; i < 3; i++) cyc("lw.mw", OP_LW, L, L, L, L, L, ST_MEM, O_MRD | O_IOD);
    cyc("lw.m3", OP_LW, H, L, L, L, L, ST_MEM,   O_MRD | O_IOD);
    cyc("lw.wb", OP_LW, H, L, L, L, L, ST_WB,    O_RW | O_M2R);
    exp_cnt++;

    // beq taken; alu_finish on the entry cycle must be ignored
    cyc("b1.f",  OP_BEQ, H, L, L, L, L, ST_FETCH, O_FRDY);
    cyc("b1.d",  OP_BEQ, L, L, L, L, L, ST_DEC,   O_NONE);
    cyc("b1.e0", OP_BEQ, L, H, H, L, L, ST_EXEC,  A_BEQ | O_START);
    cyc("b1.e1", OP_BEQ, L, H, H, L, L, ST_EXEC,  A_BEQ | O_BT);
    exp_cnt++;

    // beq not taken
    cyc("b0.f",  OP_BEQ, H, L, L, L, L, ST_FETCH, O_FRDY);
    cyc("b0.d",  OP_BEQ, L, L, L, L, L, ST_DEC,   O_NONE);
    cyc("b0.e0", OP_BEQ, L, L, L, L, L, ST_EXEC,  A_BEQ | O_START);
    cyc("b0.e1", OP_BEQ, L, H, L, L, L, ST_EXEC,  A_BEQ);
    exp_cnt++;

    // sw retiring from MEM
    cyc("sw.f",  OP_SW, H, L, L, L, L, ST_FETCH, O_FRDY);
    cyc("sw.d",  OP_SW, L, L, L, L, L, ST_DEC,   O_NONE);
    cyc("sw.e0", OP_SW, L, L, L, L, L, ST_EXEC,  A_LS | O_START);
    cyc("sw.e1", OP_SW, L, H, L, L, L, ST_EXEC,  A_LS);
    cyc("sw.m0", OP_SW, L, L, L, L, L, ST_MEM,   O_MWR | O_IOD);
    cyc("sw.m1", OP_SW, H, L, L, L, L, ST_MEM,   O_MWR | O_IOD);
    exp_cnt++;

    // sw interrupted by reset while mem_write is high
    cyc("swr.f",  OP_SW, H, L, L, L, L, ST_FETCH, O_FRDY);
    cyc("swr.d",  OP_SW, L, L, L, L, L, ST_DEC,   O_NONE);
    cyc("swr.e0", OP_SW, L, L, L, L, L, ST_EXEC,  A_LS | O_START);
    cyc("swr.e1", OP_SW, L, H, L, L, L, ST_EXEC,  A_LS);
    cyc("swr.m0", OP_SW, L, L, L, L, L, ST_MEM,   O_MWR | O_IOD);
    do_reset("swr.rst");

    // illegal opcode: sticky ERROR while inputs toggle
    cyc("ill.f", OP_BAD, H, L, L, L, L, ST_FETCH, O_FRDY);
    cyc("ill.d", OP_BAD, L, L, L, L, L, ST_DEC,   O_NONE);
    for (int i = 0; i < 20; i++)
      cyc("ill.h", OP_BAD, i[0], ~i[0], i[1], L, L, ST_ERR, O_HALT | E_OPC);
    do_reset("rst1");

    // ALU timeout after 8 EXEC cycles
    cyc("to.f",  OP_R, H, L, L, L, L, ST_FETCH, O_FRDY);
    cyc("to.d",  OP_R, L, L, L, L, L, ST_DEC,   O_NONE);
    cyc("to.e0", OP_R, L, L, L, L, L, ST_EXEC,  A_R | O_START);
    for (int i = 1; i < 8; i++) cyc("to.ew", OP_R, L, L, L, L, L, ST_EXEC, A_R);
    cyc("to.err", OP_R, L, L, L, L, L, ST_ERR, O_HALT | E_TMO);
    do_reset("rst2");

    // alu_finish on the last allowed cycle beats the timeout
    cyc("fw.f",  OP_R, H, L, L, L, L, ST_FETCH, O_FRDY);
    cyc("fw.d",  OP_R, L, L, L, L, L, ST_DEC,   O_NONE);
    cyc("fw.e0", OP_R, L, L, L, L, L, ST_EXEC,  A_R | O_START);
    for (int i = 1; i < 7; i++) cyc("fw.ew", OP_R, L, L, L, L, L, ST_EXEC, A_R);
    cyc("fw.e7", OP_R, L, H, L, L, L, ST_EXEC,  A_R);
    cyc("fw.wb", OP_R, L, L, L, L, L, ST_WB,    O_RW | O_RDST);
    exp_cnt++;

    // both ALU error flags: func-code error has priority
    cyc("ff.f",   OP_R, H, L, L, L, L, ST_FETCH, O_FRDY);
    cyc("ff.d",   OP_R, L, L, L, L, L, ST_DEC,   O_NONE);
    cyc("ff.e0",  OP_R, L, L, L, L, L, ST_EXEC,  A_R | O_START);
    cyc("ff.e1",  OP_R, L, H, L, H, H, ST_EXEC,  A_R);
    cyc("ff.err", OP_R, L, L, L, L, L, ST_ERR,   O_HALT | E_FUNC);
    do_reset("rst3");

    // alu_op error alone
    cyc("ao.f",   OP_SW, H, L, L, L, L, ST_FETCH, O_FRDY);
    cyc("ao.d",   OP_SW, L, L, L, L, L, ST_DEC,   O_NONE);
    cyc("ao.e0",  OP_SW, L, L, L, L, L, ST_EXEC,  A_LS | O_START);
    cyc("ao.e1",  OP_SW, L, H, L, L, H, ST_EXEC,  A_LS);
    cyc("ao.err", OP_SW, L, L, L, L, L, ST_ERR,   O_HALT | E_ALUOP);
    do_reset("rst4");

    // instr_count wrap: run one instruction, then preload all-ones and retire a beq
    cyc("wr.f",  OP_R, H, L, L, L, L, ST_FETCH, O_FRDY);
    cyc("wr.d",  OP_R, L, L, L, L, L, ST_DEC,   O_NONE);
    cyc("wr.e0", OP_R, L, L, L, L, L, ST_EXEC,  A_R | O_START);
    cyc("wr.e1", OP_R, L, H, L, L, L, ST_EXEC,  A_R);
    cyc("wr.wb", OP_R, L, L, L, L, L, ST_WB,    O_RW | O_RDST);
    exp_cnt++;
    cyc("wb.f",  OP_BEQ, H, L, L, L, L, ST_FETCH, O_FRDY);
    force dut.instr_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.instr_cnt_q;
    exp_cnt = 32'hFFFF_FFFF;
    cyc("wb.d",  OP_BEQ, L, L, L, L, L, ST_DEC,   O_NONE);
    cyc("wb.e0", OP_BEQ, L, L, L, L, L, ST_EXEC,  A_BEQ | O_START);
    cyc("wb.e1", OP_BEQ, L, H, L, L, L, ST_EXEC,  A_BEQ);
    exp_cnt++;
    cyc("wb.f2", OP_R, L, L, L, L, L, ST_FETCH, O_MRD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
